branch_predictor_2bit: RTL

//  Dynamic branch predictor replacing static not-taken beq handling in the 5-stage pipeline.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/sat_counter.sv | 28 ++
 rtl/branch_predictor_2bit.sv | 78 +++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared counter encodings and saturating-counter helpers for the branch predictor.
// Helpers work on 32-bit containers so that any CTR_W up to 31 can use them.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic logic [31:0] ctr_reset_val(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_next(input logic [31:0] ctr, input logic taken,
                                           input int unsigned ctr_w);
    logic [31:0] max_val;
    max_val = (32'd1 << ctr_w) - 32'd1;
    if (taken) return (ctr == max_val) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One CTR_W-bit saturating up/down counter with enable and asynchronous active-low reset.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr
);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (en) ctr_d = CTR_W'(sat_next(32'(ctr_q), taken, CTR_W));
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ctr_q <= CTR_W'(ctr_reset_val(CTR_W));
    else       ctr_q <= ctr_d;
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predictor_2bit.sv
// PC-indexed table of saturating counters with resolved-branch statistics.
// Define BP_GSHARE_EN to XOR a global history register into the lookup index.
module branch_predictor_2bit
  import bp_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [PC_W-1:0]   lookupPc,
  output logic              predTaken,
  output logic [IDX_W-1:0]  predIdx,
  input  logic              updValid,
  input  logic [IDX_W-1:0]  updIdx,
  input  logic              updTaken,
  input  logic              updMispred,
  output logic [STAT_W-1:0] branchCount,
  output logic [STAT_W-1:0] mispredCount
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [IDX_W-1:0] pc_idx, lookup_idx;
  logic [CTR_W-1:0] ctrs [Entries];
  logic             unused_pc_bits;

  assign pc_idx         = lookupPc[IDX_W+1:2];
  assign unused_pc_bits = ^{lookupPc[PC_W-1:IDX_W+2], lookupPc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // History advances only on resolved branches, never speculatively at fetch.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)         ghr_q <= '0;
    else if (updValid) ghr_q <= {ghr_q[IDX_W-2:0], updTaken};
  end

  assign lookup_idx = pc_idx ^ ghr_q;
`else
  assign lookup_idx = pc_idx;
`endif

  for (genvar i = 0; i < Entries; i++) begin : g_ctr
    sat_counter #(
      .CTR_W(CTR_W)
    ) u_ctr (
      .clk  (clk),
      .rstN (rstN),
      .en   (updValid && (updIdx == IDX_W'(i))),
      .taken(updTaken),
      .ctr  (ctrs[i])
    );
  end

  // No bypass: a same-cycle update to this entry is seen from the next cycle.
  assign predTaken = ctrs[lookup_idx][CTR_W-1];
  assign predIdx   = lookup_idx;

  logic [STAT_W-1:0] branch_q, mispred_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else if (updValid) begin
      if (branch_q != '1) branch_q <= branch_q + STAT_W'(1);
      if (updMispred && (mispred_q != '1)) mispred_q <= mispred_q + STAT_W'(1);
    end
  end

  assign branchCount  = branch_q;
  assign mispredCount = mispred_q;

endmodule
